// File: rtl/mvm_stream_arbiter_2x.sv
// Two-requester frame scheduler for one shared streaming matrix-vector network.
// Default build arbitrates round-robin; defining ARB_FIXED_PRIO_EN gives s0 fixed priority.
module mvm_stream_arbiter_2x #(
  parameter int WIDTH        = 16,
  parameter int IN_LEN       = 64,
  parameter int OUT_LEN      = 10,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s0_data_in_x,
  input  logic             s0_valid_x,
  output logic             s0_ready_x,
  input  logic [WIDTH-1:0] s1_data_in_x,
  input  logic             s1_valid_x,
  output logic             s1_ready_x,
  output logic [WIDTH-1:0] net_data_out_x,
  output logic             net_valid_x,
  input  logic             net_ready_x,
  input  logic [WIDTH-1:0] net_data_in_y,
  input  logic             net_valid_y,
  output logic             net_ready_y,
  output logic [WIDTH-1:0] m0_data_out_y,
  output logic             m0_valid_y,
  input  logic             m0_ready_y,
  output logic [WIDTH-1:0] m1_data_out_y,
  output logic             m1_valid_y,
  input  logic             m1_ready_y
);

  localparam int IN_CW  = (IN_LEN > 2) ? $clog2(IN_LEN) : 1;
  localparam int OUT_CW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int PTR_W  = $clog2(MAX_INFLIGHT);
  localparam logic [IN_CW-1:0]  IN_LAST    = IN_CW'(IN_LEN - 1);
  localparam logic [OUT_CW-1:0] OUT_LAST   = OUT_CW'(OUT_LEN - 1);
  localparam logic [PTR_W:0]    FIFO_DEPTH = (PTR_W + 1)'(MAX_INFLIGHT);

  typedef enum logic {S_IDLE, S_FEED} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic [IN_CW-1:0]    in_cnt_q, in_cnt_d;
  logic [OUT_CW-1:0]   out_cnt_q, out_cnt_d;
  logic [MAX_INFLIGHT-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;

  logic fifo_full, fifo_empty, head, grant, grant_sel, in_xfer, out_xfer, pop;

  assign fifo_full  = (count_q == FIFO_DEPTH);
  assign fifo_empty = (count_q == '0);
  assign head       = tag_q[rd_ptr_q];

`ifdef ARB_FIXED_PRIO_EN
  assign grant_sel = ~s0_valid_x;
`else
  assign grant_sel = (s0_valid_x && s1_valid_x) ? ~last_owner_q : ~s0_valid_x;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Full check uses the pre-edge count, so a same-cycle pop never enables a grant.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_full && (s0_valid_x || s1_valid_x)) begin
          grant   = 1'b1;
          state_d = S_FEED;
        end
      end
      S_FEED: begin
        if (in_xfer && (in_cnt_q == IN_LAST)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    net_data_out_x = owner_q ? s1_data_in_x : s0_data_in_x;
    net_valid_x    = 1'b0;
    s0_ready_x     = 1'b0;
    s1_ready_x     = 1'b0;
    if (reset && (state_q == S_FEED)) begin
      net_valid_x = owner_q ? s1_valid_x : s0_valid_x;
      s0_ready_x  = ~owner_q & net_ready_x;
      s1_ready_x  = owner_q & net_ready_x;
    end
    net_ready_y   = 1'b0;
    m0_valid_y    = 1'b0;
    m1_valid_y    = 1'b0;
    m0_data_out_y = net_data_in_y;
    m1_data_out_y = net_data_in_y;
    if (reset && !fifo_empty) begin
      net_ready_y = head ? m1_ready_y : m0_ready_y;
      m0_valid_y  = ~head & net_valid_y;
      m1_valid_y  = head & net_valid_y;
    end
  end

  assign in_xfer  = net_valid_x & net_ready_x;
  assign out_xfer = net_valid_y & net_ready_y;
  assign pop      = out_xfer && (out_cnt_q == OUT_LAST);

  always_comb begin
    owner_d      = grant ? grant_sel : owner_q;
    last_owner_d = last_owner_q;
    in_cnt_d     = in_cnt_q;
    if (grant) begin
      in_cnt_d = '0;
    end else if (in_xfer) begin
      in_cnt_d = in_cnt_q + 1'b1;
      if (in_cnt_q == IN_LAST) last_owner_d = owner_q;
    end

    out_cnt_d = out_cnt_q;
    if (pop)           out_cnt_d = '0;
    else if (out_xfer) out_cnt_d = out_cnt_q + 1'b1;

    tag_d = tag_q;
    if (grant) tag_d[wr_ptr_q] = grant_sel;
    wr_ptr_d = wr_ptr_q + PTR_W'(grant);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    unique case ({grant, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

endmodule

// File: tb/tb_mvm_stream_arbiter_2x.sv
// Bench for mvm_stream_arbiter_2x: stub network returns (vector sum + k) for word k, and a
// per-stream scoreboard checks every routed word, grant order, bubbles and the inflight limit.
module tb_mvm_stream_arbiter_2x;
  localparam int WIDTH = 16, IN_LEN = 4, OUT_LEN = 2, MAX_INFLIGHT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [WIDTH-1:0] s0_data_in_x, s1_data_in_x, net_data_out_x, net_data_in_y;
  logic [WIDTH-1:0] m0_data_out_y, m1_data_out_y;
  logic s0_valid_x, s0_ready_x, s1_valid_x, s1_ready_x;
  logic net_valid_x, net_ready_x, net_valid_y, net_ready_y;
  logic m0_valid_y, m0_ready_y, m1_valid_y, m1_ready_y;

  always #5 clk = ~clk;

  mvm_stream_arbiter_2x #(.WIDTH(WIDTH), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN),
                          .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk(clk), .reset(reset),
    .s0_data_in_x(s0_data_in_x), .s0_valid_x(s0_valid_x), .s0_ready_x(s0_ready_x),
    .s1_data_in_x(s1_data_in_x), .s1_valid_x(s1_valid_x), .s1_ready_x(s1_ready_x),
    .net_data_out_x(net_data_out_x), .net_valid_x(net_valid_x), .net_ready_x(net_ready_x),
    .net_data_in_y(net_data_in_y), .net_valid_y(net_valid_y), .net_ready_y(net_ready_y),
    .m0_data_out_y(m0_data_out_y), .m0_valid_y(m0_valid_y), .m0_ready_y(m0_ready_y),
    .m1_data_out_y(m1_data_out_y), .m1_valid_y(m1_valid_y), .m1_ready_y(m1_ready_y)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;
  logic rst_drv = 1'b0;
  logic [WIDTH-1:0] src_q [2][$];
  logic [WIDTH-1:0] exp_out [2][$];
  logic [WIDTH-1:0] net_out_q [$];
  int net_src_q [$];
  int vec_start_q [$];
  logic s_vld [2];
  logic n_vld;
  logic [WIDTH-1:0] acc_sum [2];
  int acc_cnt [2];
  logic [WIDTH-1:0] net_sum;
  int net_in_idx, cur_src, out_idx;
  int p_sval, p_nrdy, p_nval;
  int p_mrdy [2];
  int cnt_rdy [2], first_rdy [2], cnt_mval [2], cnt_mx [2];
  int stall_cyc, first_pop, first_rdy_any, mark_cyc;
  logic last_nry, m1_pend_prev;
  logic [WIDTH-1:0] m1_prev_data;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic rnd(int p);
    return ($urandom_range(99) < p);
  endfunction

  function automatic logic drained();
    return src_q[0].size() == 0 && src_q[1].size() == 0 && !s_vld[0] && !s_vld[1] &&
           acc_cnt[0] == 0 && acc_cnt[1] == 0 && net_in_idx == 0 && net_out_q.size() == 0 &&
           exp_out[0].size() == 0 && exp_out[1].size() == 0;
  endfunction

  task automatic stats_clear();
    for (int i = 0; i < 2; i++) begin
      cnt_rdy[i] = 0; first_rdy[i] = -1; cnt_mval[i] = 0; cnt_mx[i] = 0;
    end
    stall_cyc = 0; first_pop = -1; first_rdy_any = -1; mark_cyc = cyc;
    net_src_q.delete(); vec_start_q.delete();
  endtask

  task automatic env_reset();
    for (int i = 0; i < 2; i++) begin
      src_q[i].delete(); exp_out[i].delete();
      s_vld[i] = 1'b0; acc_sum[i] = '0; acc_cnt[i] = 0; p_mrdy[i] = 100;
    end
    net_out_q.delete();
    n_vld = 1'b0; net_sum = '0; net_in_idx = 0; cur_src = 0; out_idx = 0;
    p_sval = 100; p_nrdy = 100; p_nval = 100;
    m1_pend_prev = 1'b0; m1_prev_data = '0; last_nry = 1'b0;
    stats_clear();
  endtask

  task automatic push_rand_vecs(int s, int n);
    for (int v = 0; v < n; v++)
      for (int w = 0; w < IN_LEN; w++) src_q[s].push_back(WIDTH'($urandom));
  endtask

  task automatic cycle();
    logic x [2];
    logic mx [2];
    logic rdy [2];
    logic mv [2];
    logic [WIDTH-1:0] md [2];
    logic nx, ox;
    logic [WIDTH-1:0] w;
    @(negedge clk);
    reset = rst_drv;
    for (int i = 0; i < 2; i++)
      if (!s_vld[i] && src_q[i].size() > 0 && rnd(p_sval)) s_vld[i] = 1'b1;
    s0_valid_x = s_vld[0]; s0_data_in_x = s_vld[0] ? src_q[0][0] : '0;
    s1_valid_x = s_vld[1]; s1_data_in_x = s_vld[1] ? src_q[1][0] : '0;
    net_ready_x = rnd(p_nrdy);
    if (!n_vld && net_out_q.size() > 0 && rnd(p_nval)) n_vld = 1'b1;
    net_valid_y = n_vld; net_data_in_y = n_vld ? net_out_q[0] : '0;
    m0_ready_y = rnd(p_mrdy[0]); m1_ready_y = rnd(p_mrdy[1]);
    #1;
    if (!reset) begin
      chk("reset_quiet", {s0_ready_x, s1_ready_x, net_valid_x, net_ready_y, m0_valid_y, m1_valid_y}, 0);
      m1_pend_prev = 1'b0;
    end else begin
      rdy[0] = s0_ready_x; rdy[1] = s1_ready_x;
      x[0] = s0_valid_x & s0_ready_x; x[1] = s1_valid_x & s1_ready_x;
      nx = net_valid_x & net_ready_x;
      mv[0] = m0_valid_y; mv[1] = m1_valid_y;
      md[0] = m0_data_out_y; md[1] = m1_data_out_y;
      mx[0] = m0_valid_y & m0_ready_y; mx[1] = m1_valid_y & m1_ready_y;
      ox = net_valid_y & net_ready_y;
      chk("s_ready_onehot", s0_ready_x & s1_ready_x, 0);
      chk("s_xfer_is_net_xfer", x[0] | x[1], nx);
      if (nx) begin
        if (net_in_idx == 0) begin
          cur_src = int'(x[1]);
          net_src_q.push_back(int'(x[1]));
          vec_start_q.push_back(cyc);
        end else begin
          chk("vec_contiguous", int'(x[1]), cur_src);
        end
        if (x[0] | x[1]) chk("net_data", net_data_out_x, src_q[int'(x[1])][0]);
        net_sum += net_data_out_x;
        net_in_idx++;
        if (net_in_idx == IN_LEN) begin
          for (int k = 0; k < OUT_LEN; k++) net_out_q.push_back(net_sum + WIDTH'(k));
          net_sum = '0; net_in_idx = 0;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (x[i]) begin
          w = src_q[i].pop_front();
          s_vld[i] = 1'b0;
          acc_sum[i] += w;
          acc_cnt[i]++;
          if (acc_cnt[i] == IN_LEN) begin
            for (int k = 0; k < OUT_LEN; k++) exp_out[i].push_back(acc_sum[i] + WIDTH'(k));
            acc_sum[i] = '0; acc_cnt[i] = 0;
          end
        end
        if (rdy[i]) begin
          cnt_rdy[i]++;
          if (first_rdy[i] < 0) first_rdy[i] = cyc;
        end
        if (mv[i]) cnt_mval[i]++;
        if (mx[i]) begin
          cnt_mx[i]++;
          chk(i == 0 ? "m0_word_pending" : "m1_word_pending", exp_out[i].size() != 0, 1);
          if (exp_out[i].size() != 0) chk(i == 0 ? "m0_data" : "m1_data", md[i], exp_out[i].pop_front());
        end
      end
      chk("m_valid_onehot", m0_valid_y & m1_valid_y, 0);
      chk("route_xfer", mx[0] | mx[1], ox);
      if (m1_pend_prev) begin
        chk("m1_hold_valid", m1_valid_y, 1);
        chk("m1_hold_data", m1_data_out_y, m1_prev_data);
      end
      if (m1_valid_y && !m1_ready_y) begin
        stall_cyc++;
        chk("stall_net_ready", net_ready_y, 0);
        chk("stall_m0_valid", m0_valid_y, 0);
      end
      m1_pend_prev = m1_valid_y & ~m1_ready_y;
      m1_prev_data = m1_data_out_y;
      if (ox) begin
        void'(net_out_q.pop_front());
        n_vld = 1'b0;
        out_idx++;
        if (out_idx == OUT_LEN) begin
          out_idx = 0;
          if (first_pop < 0 && cyc >= mark_cyc) first_pop = cyc;
        end
      end
      if (first_rdy_any < 0 && cyc >= mark_cyc && (s0_ready_x | s1_ready_x)) first_rdy_any = cyc;
      last_nry = net_ready_y;
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic drain(int budget, string tag);
    int n = 0;
    while (!drained() && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, drained(), 1);
  endtask

  task automatic do_reset();
    env_reset();
    rst_drv = 1'b0;
    repeat (2) cycle();
    rst_drv = 1'b1;
  endtask

  initial begin
    int rel;
    int e;
    // Single s0 vector with valids asserted during reset.
    env_reset();
    for (int w = 1; w <= IN_LEN; w++) src_q[0].push_back(WIDTH'(w));
    rst_drv = 1'b0;
    repeat (3) cycle();
    rst_drv = 1'b1;
    rel = cyc;
    drain(60, "single_drain");
    cycle();
    chk("single_s0_ready_cycles", cnt_rdy[0], IN_LEN);
    chk("single_s1_ready_cycles", cnt_rdy[1], 0);
    chk("single_grant_bubble", first_rdy[0], rel + 1);
    chk("single_m0_words", cnt_mx[0], OUT_LEN);
    chk("single_m1_valid_cycles", cnt_mval[1], 0);
    chk("single_fifo_empty", last_nry, 0);

    // Both requesters always valid: grant order and one-cycle bubble between vectors.
    do_reset();
    push_rand_vecs(0, 4); push_rand_vecs(1, 4);
    drain(200, "alt_drain");
    chk("alt_vec_count", net_src_q.size(), 8);
    for (int k = 0; k < 8 && k < net_src_q.size(); k++) begin
`ifdef ARB_FIXED_PRIO_EN
      e = (k < 4) ? 0 : 1;
`else
      e = k % 2;
`endif
      chk("grant_order", net_src_q[k], e);
      if (k > 0) chk("grant_gap", vec_start_q[k] - vec_start_q[k-1], IN_LEN + 1);
    end

    // m1 consumer stalled while its vector is at the head.
    do_reset();
    push_rand_vecs(0, 2); push_rand_vecs(1, 2);
    p_mrdy[1] = 0;
    repeat (40) cycle();
    chk("m1_stall_long", stall_cyc >= 20, 1);
    p_mrdy[1] = 100;
    drain(200, "stall_drain");

    // Output stalled: inflight limit, then regrant the cycle after the first pop.
    do_reset();
    push_rand_vecs(0, 4); push_rand_vecs(1, 4);
    p_nval = 0;
    repeat (40) cycle();
    chk("inflight_granted", net_src_q.size(), MAX_INFLIGHT);
    mark_cyc = cyc; first_pop = -1; first_rdy_any = -1;
    p_nval = 100;
    drain(400, "inflight_drain");
    chk("regrant_latency", first_rdy_any - first_pop, 2);

    // Mid-vector reset after s1 became owner.
    do_reset();
    push_rand_vecs(0, 1);
    drain(60, "pre_midreset_drain");
    push_rand_vecs(1, 1);
    for (int n = 0; n < 40 && acc_cnt[1] < 2; n++) cycle();
    chk("midreset_partial", acc_cnt[1], 2);
    rst_drv = 1'b0;
    cycle();
    env_reset();
    cycle();
    rst_drv = 1'b1;
    cycle();
    chk("midreset_fifo_empty", last_nry, 0);
    stats_clear();
    push_rand_vecs(0, 1); push_rand_vecs(1, 1);
    drain(100, "post_midreset_drain");
    chk("post_reset_first_owner", net_src_q.size() > 0 ? net_src_q[0] : -1, 0);

    // Randomized traffic rounds.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      push_rand_vecs(0, $urandom_range(6, 2));
      push_rand_vecs(1, $urandom_range(6, 2));
      p_sval = $urandom_range(100, 30); p_nrdy = $urandom_range(100, 30);
      p_nval = $urandom_range(100, 30);
      p_mrdy[0] = $urandom_range(100, 30); p_mrdy[1] = $urandom_range(100, 30);
      drain(3000, "random_drain");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
